// File: rtl/dda_pkg.sv
// Shared definitions for the DDA core and its trace buffer.
package dda_pkg;

  // Posit word defaults shared with the DDA core.
  localparam int N_DEF  = 16;
  localparam int ES_DEF = 1;

  // Trace buffer capture sequencer states (debug-visible encoding).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  // Bit index of the posit sign bit for an n-bit word.
  function automatic int sign_idx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/dda_trace_buffer_if.sv
// Capture/readout bus between the DDA, the trace buffer and the SPI readout logic.
interface dda_trace_buffer_if #(
  parameter int N     = 16,
  parameter int DEPTH = 16,
  parameter int DEC_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             step_valid;
  logic [N-1:0]     x;
  logic [N-1:0]     y;
  logic [DEC_W-1:0] decim;
  logic             arm;
  logic             abort;
  logic             trig_en;
  logic             one_shot;
  logic             clear;
  logic             pop;
  logic [2*N-1:0]   dout;
  logic             dout_valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [1:0]       state;

  modport master (
    output step_valid, x, y, decim, arm, abort, trig_en, one_shot, clear, pop,
    input  dout, dout_valid, empty, full, count, overflow, state
  );

  modport slave (
    input  step_valid, x, y, decim, arm, abort, trig_en, one_shot, clear, pop,
    output dout, dout_valid, empty, full, count, overflow, state
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered flags and synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             empty_r, full_r, rd_valid_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             wr_ok_s, rd_ok_s;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign rd_ok_s = rd_en && !empty_r;
  assign wr_ok_s = wr_en && (!full_r || rd_ok_s);

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, flags and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else if (clear) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == CW'(0));
      full_r     <= (count_nxt_s == CW'(DEPTH));
      rd_valid_r <= rd_ok_s;
    end
  end

  // Storage array; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !clear) mem_r[wr_ptr_r] <= wr_data;
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;
endmodule

// File: rtl/dda_trace_buffer.sv
// Trace capture of decimated DDA {x,y} posit pairs with optional sign-crossing trigger.
module dda_trace_buffer
  import dda_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = 16,
  parameter int DEC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  dda_trace_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  trace_state_e     state_r, state_nxt_s;
  logic [DEC_W-1:0] dec_cnt_r;
  logic             prev_sign_r;
  logic             overflow_r;

  logic             x_sign_s, trigger_s, step_cap_s, adv_s;
  logic             push_s, pop_s, drop_s, fills_s, arm_ok_s;
  logic             fifo_empty_s, fifo_full_s, fifo_rd_valid_s;
  logic [CW-1:0]    fifo_count_s;
  logic [2*N-1:0]   fifo_rd_data_s;

  assign x_sign_s   = bus.x[sign_idx(N)];
  assign trigger_s  = (state_r == ARMED) && bus.trig_en && bus.step_valid &&
                      prev_sign_r && !x_sign_s;
  assign step_cap_s = (state_r == CAPTURE) && bus.step_valid;
  assign adv_s      = step_cap_s || trigger_s;
  assign arm_ok_s   = bus.arm && !bus.abort && ((state_r == IDLE) || (state_r == DONE));

  // The triggering sample is decimation index 0, so it is always stored.
  assign push_s  = !bus.clear && !bus.abort &&
                   (trigger_s || (step_cap_s && (dec_cnt_r == DEC_W'(0))));
  assign pop_s   = bus.pop && !bus.clear;
  assign drop_s  = push_s && fifo_full_s && !pop_s;
  assign fills_s = push_s && !(pop_s && !fifo_empty_s) &&
                   (fifo_count_s == CW'(DEPTH - 1));

  // Capture sequencer next state; abort overrides everything, including arm.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.arm) state_nxt_s = ARMED;
          else         state_nxt_s = state_r;
        end
        ARMED: begin
          if (!bus.trig_en)                   state_nxt_s = CAPTURE;
          else if (trigger_s && bus.one_shot && fills_s) state_nxt_s = DONE;
          else if (trigger_s)                 state_nxt_s = CAPTURE;
          else                                state_nxt_s = ARMED;
        end
        CAPTURE: begin
          if (bus.one_shot && fills_s) state_nxt_s = DONE;
          else                         state_nxt_s = CAPTURE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Decimation counter: restarts on arm and clear, advances on every captured step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     dec_cnt_r <= '0;
    else if (bus.clear)          dec_cnt_r <= '0;
    else if (arm_ok_s)           dec_cnt_r <= '0;
    else if (adv_s && !bus.abort)
      dec_cnt_r <= (dec_cnt_r == bus.decim) ? DEC_W'(0) : dec_cnt_r + DEC_W'(1);
  end

  // Sign history for the negative-to-non-negative crossing, tracked only while armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       prev_sign_r <= 1'b0;
    else if ((state_r == ARMED) && bus.step_valid) prev_sign_r <= x_sign_s;
  end

  // Sticky flag for samples lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow_r <= 1'b0;
    else if (bus.clear) overflow_r <= 1'b0;
    else if (drop_s)    overflow_r <= 1'b1;
  end

  sync_fifo #(.WIDTH(2*N), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.clear),
    .wr_en    (push_s),
    .wr_data  ({bus.x, bus.y}),
    .rd_en    (pop_s),
    .rd_data  (fifo_rd_data_s),
    .rd_valid (fifo_rd_valid_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s),
    .count    (fifo_count_s)
  );

  assign bus.dout       = fifo_rd_data_s;
  assign bus.dout_valid = fifo_rd_valid_s;
  assign bus.empty      = fifo_empty_s;
  assign bus.full       = fifo_full_s;
  assign bus.count      = fifo_count_s;
  assign bus.overflow   = overflow_r;
  assign bus.state      = state_r;
endmodule

// File: tb/tb_dda_trace_buffer.sv
// Directed, self-checking bench for the DDA trace buffer.
module tb_dda_trace_buffer;
  localparam int N     = 16;
  localparam int DEPTH = 16;
  localparam int DEC_W = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dda_trace_buffer_if #(.N(N), .DEPTH(DEPTH), .DEC_W(DEC_W)) bus ();

  dda_trace_buffer #(.N(N), .DEPTH(DEPTH), .DEC_W(DEC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        step;
    logic [15:0] x;
    logic [15:0] y;
    logic        pop;
    logic [4:0]  exp_count;
    logic        exp_dv;
    logic [31:0] exp_dout;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vec [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] xv, input logic [15:0] yv, input logic p);
    bus.step_valid = 1'b1;
    bus.x          = xv;
    bus.y          = yv;
    bus.pop        = p;
    tick();
    bus.step_valid = 1'b0;
    bus.pop        = 1'b0;
  endtask

  task automatic do_pop();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.step_valid = 1'b0; bus.x = 16'h0; bus.y = 16'h0; bus.decim = 8'd0;
    bus.arm = 1'b0; bus.abort = 1'b0; bus.trig_en = 1'b0; bus.one_shot = 1'b0;
    bus.clear = 1'b0; bus.pop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state.
    chk("rst_state",    bus.state,      S_IDLE);
    chk("rst_empty",    bus.empty,      1'b1);
    chk("rst_full",     bus.full,       1'b0);
    chk("rst_count",    bus.count,      5'd0);
    chk("rst_dout",     bus.dout,       32'h0);
    chk("rst_dv",       bus.dout_valid, 1'b0);
    chk("rst_overflow", bus.overflow,   1'b0);

    // arm and abort together: abort wins.
    bus.arm = 1'b1; bus.abort = 1'b1;
    tick();
    bus.arm = 1'b0; bus.abort = 1'b0;
    chk("arm_abort_prio", bus.state, S_IDLE);

    // Test 1: free-running capture, decim=0, table-driven push/pop sequence.
    for (int i = 0; i < 5; i++) begin
      vec[i] = '{step: 1'b1, x: 16'h3000 + 16'(i), y: 16'h4000 + 16'(i), pop: 1'b0,
                 exp_count: 5'(i + 1), exp_dv: 1'b0, exp_dout: 32'h0, exp_state: S_CAPTURE};
    end
    for (int k = 0; k < 5; k++) begin
      vec[5 + k] = '{step: 1'b0, x: 16'h0, y: 16'h0, pop: 1'b1,
                     exp_count: 5'(4 - k), exp_dv: 1'b1,
                     exp_dout: {16'h3000 + 16'(k), 16'h4000 + 16'(k)}, exp_state: S_CAPTURE};
    end
    vec[10] = '{step: 1'b0, x: 16'h0, y: 16'h0, pop: 1'b0, exp_count: 5'd0,
                exp_dv: 1'b0, exp_dout: 32'h30044004, exp_state: S_CAPTURE};
    vec[11] = '{step: 1'b0, x: 16'h0, y: 16'h0, pop: 1'b1, exp_count: 5'd0,
                exp_dv: 1'b0, exp_dout: 32'h30044004, exp_state: S_CAPTURE};

    pulse_arm();
    chk("t1_armed", bus.state, S_ARMED);
    tick();
    chk("t1_capture", bus.state, S_CAPTURE);
    for (int i = 0; i < 12; i++) begin
      bus.step_valid = vec[i].step;
      bus.x          = vec[i].x;
      bus.y          = vec[i].y;
      bus.pop        = vec[i].pop;
      tick();
      bus.step_valid = 1'b0;
      bus.pop        = 1'b0;
      chk($sformatf("t1_v%0d_count", i), bus.count,      vec[i].exp_count);
      chk($sformatf("t1_v%0d_dv",    i), bus.dout_valid, vec[i].exp_dv);
      chk($sformatf("t1_v%0d_dout",  i), bus.dout,       vec[i].exp_dout);
      chk($sformatf("t1_v%0d_state", i), bus.state,      vec[i].exp_state);
    end
    pulse_abort();
    chk("t1_abort_idle", bus.state, S_IDLE);

    // Test 2: decim=2 keeps steps 0, 3, 6.
    bus.decim = 8'd2;
    pulse_arm();
    tick();
    for (int i = 0; i < 9; i++) step(16'(i), 16'h0000, 1'b0);
    chk("t2_count", bus.count, 5'd3);
    for (int k = 0; k < 3; k++) begin
      do_pop();
      chk($sformatf("t2_pop%0d", k), bus.dout, {16'(3 * k), 16'h0000});
    end
    pulse_abort();
    bus.decim = 8'd0;

    // Test 3: trigger on negative -> non-negative crossing of x.
    bus.trig_en = 1'b1;
    pulse_arm();
    step(16'hC000, 16'h0055, 1'b0);
    chk("t3_armed1", bus.state, S_ARMED);
    step(16'hC000, 16'h0055, 1'b0);
    chk("t3_armed2", bus.state, S_ARMED);
    chk("t3_cnt0",   bus.count, 5'd0);
    step(16'h1000, 16'h0055, 1'b0);
    chk("t3_trig",   bus.state, S_CAPTURE);
    step(16'h2000, 16'h0055, 1'b0);
    chk("t3_count",  bus.count, 5'd2);
    do_pop();
    chk("t3_first",  bus.dout, 32'h10000055);
    do_pop();
    chk("t3_second", bus.dout, 32'h20000055);
    pulse_abort();
    bus.trig_en = 1'b0;

    // Test 4a: one-shot stops at the 16th push.
    bus.one_shot = 1'b1;
    pulse_arm();
    tick();
    for (int i = 0; i < 20; i++) begin
      step(16'h0100 + 16'(i), 16'h0011, 1'b0);
      if (i == 15) begin
        chk("t4_done_at16", bus.state, S_DONE);
        chk("t4_full_at16", bus.full,  1'b1);
      end
    end
    chk("t4_os_state", bus.state,    S_DONE);
    chk("t4_os_count", bus.count,    5'd16);
    chk("t4_os_ovf",   bus.overflow, 1'b0);
    do_pop();
    chk("t4_os_oldest", bus.dout, 32'h01000011);
    pulse_clear();
    chk("t4_clr_count", bus.count, 5'd0);
    chk("t4_clr_state", bus.state, S_DONE);

    // Test 4b: continuous mode overflows and keeps the first 16 samples.
    bus.one_shot = 1'b0;
    pulse_arm();
    tick();
    for (int i = 0; i < 20; i++) step(16'h0200 + 16'(i), 16'h0022, 1'b0);
    chk("t4_cont_state", bus.state,    S_CAPTURE);
    chk("t4_cont_count", bus.count,    5'd16);
    chk("t4_cont_ovf",   bus.overflow, 1'b1);
    for (int k = 0; k < 16; k++) begin
      do_pop();
      chk($sformatf("t4_cont_pop%0d", k), bus.dout, {16'h0200 + 16'(k), 16'h0022});
    end
    chk("t4_cont_empty", bus.empty, 1'b1);
    pulse_clear();
    chk("t4_clr_ovf", bus.overflow, 1'b0);

    // Test 5: push and pop together on a full FIFO.
    for (int i = 0; i < 16; i++) step(16'h0300 + 16'(i), 16'h0033, 1'b0);
    chk("t5_full",  bus.full,     1'b1);
    chk("t5_ovf0",  bus.overflow, 1'b0);
    step(16'hAAAA, 16'h0033, 1'b1);
    chk("t5_count", bus.count,    5'd16);
    chk("t5_ovf",   bus.overflow, 1'b0);
    chk("t5_dv",    bus.dout_valid, 1'b1);
    chk("t5_dout",  bus.dout,     32'h03000033);
    do_pop();
    chk("t5_next",  bus.dout,     32'h03010033);
    chk("t5_cnt15", bus.count,    5'd15);

    // Test 6: push with pop on empty, then async reset mid-capture.
    pulse_clear();
    step(16'h0400, 16'h0044, 1'b1);
    chk("t6_empty_pp_count", bus.count,      5'd1);
    chk("t6_empty_pp_dv",    bus.dout_valid, 1'b0);
    for (int i = 1; i < 7; i++) step(16'h0400 + 16'(i), 16'h0044, 1'b0);
    chk("t6_count7", bus.count, 5'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_count", bus.count, 5'd0);
    chk("t6_rst_empty", bus.empty, 1'b1);
    chk("t6_rst_state", bus.state, S_IDLE);
    chk("t6_rst_dout",  bus.dout,  32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_state", bus.state, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dda_trace_buffer.md
Name: dda_trace_buffer

Overview:
- Downstream consumer of the Van-der-Pol DDA outputs x/y; sits between the DDA core and the SPI readout path in the top level.
- Captures decimated {x,y} posit sample pairs into an on-chip FIFO, after an optional trigger on x's sign crossing.
- SPI logic pops entries for host readout; overflow is flagged rather than stalling the DDA.

Parameters:
- N, 16, posit word width of x and y
- DEPTH, 16, FIFO entries (power of two, >=2)
- DEC_W, 8, width of decimation ratio

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- step_valid  in  1  one-cycle pulse: DDA advanced, x/y valid this cycle
- x  in  N  DDA state x (posit)
- y  in  N  DDA state y (posit)
- decim  in  DEC_W  keep one sample every decim+1 steps
- arm  in  1  pulse: start a capture sequence
- abort  in  1  pulse: return to IDLE, keep FIFO contents
- trig_en  in  1  1 = wait for x sign crossing negative->non-negative
- one_shot  in  1  1 = stop capturing when FIFO becomes full
- clear  in  1  synchronous flush of FIFO, counters, overflow
- pop  in  1  read request
- dout  out  2N  {x,y} of popped entry
- dout_valid  out  1  dout updated this cycle
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: sample dropped because full
- state  out  2  current FSM state (debug)

Behaviour:
- Reset (async, rst=1): state=IDLE, FIFO pointers/count=0, empty=1, full=0, dout=0, dout_valid=0, overflow=0, decimation counter=0, prev_sign=0.
- States: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE/DONE -> ARMED on arm; decimation counter zeroed.
  - ARMED -> CAPTURE:
    - trig_en=0: next clock after entering ARMED.
    - trig_en=1: on a step_valid with prev_sign=1 and x[N-1]=0.
    - prev_sign updates on every step_valid in ARMED only.
    - The triggering sample is pushed as the first sample (counter counts it as index 0).
  - CAPTURE -> DONE when one_shot=1 and a push makes count==DEPTH.
  - Any state -> IDLE on abort; abort has priority over arm in the same cycle.
- Decimation, CAPTURE only, on each step_valid:
  - counter==0: push {x,y}.
  - Then counter <= (counter==decim) ? 0 : counter+1.
  - decim=0 pushes every step.
- Push when full and no pop in the same cycle: sample dropped, overflow<=1.
- Pop:
  - pop && !empty: dout <= head, dout_valid=1 on the next cycle, count decrements.
  - pop when empty: ignored, dout_valid=0, no error.
- Simultaneous push and pop:
  - Both happen, count unchanged.
  - When full, the push succeeds (slot freed the same cycle); no overflow.
  - When empty, the pop is ignored and the push succeeds.
- Pointers wrap modulo DEPTH; full = count==DEPTH; empty = count==0.
- clear: next cycle count=0, pointers=0, overflow=0, counter=0, dout_valid=0. FSM state unchanged. Same-cycle push/pop discarded.
- dout holds its last value when no pop. Latency from pop to data is 1 cycle.
- Reset mid-capture: everything returns to reset values immediately; no partial entry survives.

Decomposition:
- dda_pkg holds:
  - N, ES defaults shared with the DDA core.
  - State encoding constants IDLE/ARMED/CAPTURE/DONE.
  - Posit sign-bit index function (N-1).
- Sub-module sync_fifo (WIDTH=2N, DEPTH): storage, pointers, count, empty/full, registered read, clear.
- dda_trace_buffer holds the FSM, trigger, decimation and overflow logic.

Test Plan:
- arm, trig_en=0, decim=0, 5 step_valid with x=16'h3000+i, y=16'h4000+i -> count=5; 5 pops return 32'h30004000..32'h30044004 in order, dout_valid one cycle after each pop.
- decim=2, 9 steps x=i -> entries x=0,3,6 only; count=3.
- trig_en=1, x sequence 16'hC000,16'hC000,16'h1000,16'h2000 -> ARMED until third step; first entry x=16'h1000; count=2.
- one_shot=1, DEPTH=16, 20 steps -> state=DONE after 16th push, count=16, overflow=0. Repeat with one_shot=0 -> overflow=1, FIFO holds first 16 samples.
- Full FIFO, push and pop in same cycle -> count stays 16, overflow=0, popped data = oldest entry.
- rst asserted mid-CAPTURE with count=7 -> count=0, empty=1, state=IDLE, dout=0 without a clock edge. clear with overflow=1 -> overflow=0 next cycle.
